// File: rtl/ldm_stm_sequencer.sv
// Block-transfer sequencer for LDM/STM: walks the register list lowest-first, one register
// per cycle, then issues the base writeback. Outputs decode from the state so reset clears them at once.
module ldm_stm_sequencer (
  input  logic        CLK_n,
  input  logic        Reset,
  input  logic        Start,
  input  logic        L,
  input  logic        P,
  input  logic        U,
  input  logic        W,
  input  logic [3:0]  Rn,
  input  logic [15:0] RegList,
  input  logic [31:0] Base,
  input  logic [31:0] RD2,
  input  logic [31:0] ReadData,
  output logic        Busy,
  output logic        Done,
  output logic [3:0]  A2,
  output logic [3:0]  A3,
  output logic        WE3,
  output logic [31:0] WD3,
  output logic [31:0] MemAddr,
  output logic        MemWE,
  output logic [31:0] MemWD,
  output logic        PCWrite,
  output logic [31:0] PCData
);

  typedef enum logic [1:0] {S_IDLE, S_XFER, S_WB, S_DONE} state_e;

  state_e      state_q, state_d;
  logic [15:0] mask_q, mask_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] fbase_q, fbase_d;
  logic        l_q, l_d;
  logic        w_q, w_d;
  logic [3:0]  rn_q, rn_d;
  logic        rn_hit_q, rn_hit_d;

  logic [4:0]  cnt;
  logic [31:0] four_n;
  logic [3:0]  cur_r;
  logic [15:0] mask_clr;

  // Register count of the incoming list and lowest pending register of the active one.
  always_comb begin
    cnt = 5'd0;
    for (int i = 0; i < 16; i++) cnt = cnt + 5'(RegList[i]);
    four_n = 32'(cnt) << 2;
    cur_r = 4'd0;
    for (int i = 15; i >= 0; i--) if (mask_q[i]) cur_r = 4'(i);
    mask_clr = mask_q & ~(16'(1) << cur_r);
  end

  always_ff @(posedge CLK_n or posedge Reset) begin
    if (Reset) begin
      state_q  <= S_IDLE;
      mask_q   <= 16'd0;
      addr_q   <= 32'd0;
      fbase_q  <= 32'd0;
      l_q      <= 1'b0;
      w_q      <= 1'b0;
      rn_q     <= 4'd0;
      rn_hit_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      mask_q   <= mask_d;
      addr_q   <= addr_d;
      fbase_q  <= fbase_d;
      l_q      <= l_d;
      w_q      <= w_d;
      rn_q     <= rn_d;
      rn_hit_q <= rn_hit_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    mask_d   = mask_q;
    addr_d   = addr_q;
    fbase_d  = fbase_q;
    l_d      = l_q;
    w_d      = w_q;
    rn_d     = rn_q;
    rn_hit_d = rn_hit_q;
    Busy     = 1'b0;
    Done     = 1'b0;
    A2       = 4'd0;
    A3       = 4'd0;
    WE3      = 1'b0;
    WD3      = 32'd0;
    MemAddr  = 32'd0;
    MemWE    = 1'b0;
    MemWD    = 32'd0;
    PCWrite  = 1'b0;
    PCData   = 32'd0;

    case (state_q)
      S_IDLE: begin
        if (Start) begin
          l_d      = L;
          w_d      = W;
          rn_d     = Rn;
          rn_hit_d = RegList[Rn];
          mask_d   = RegList;
          fbase_d  = U ? (Base + four_n) : (Base - four_n);
          // Lowest register lands at the lowest address in every mode.
          case ({P, U})
            2'b01:   addr_d = Base;
            2'b11:   addr_d = Base + 32'd4;
            2'b00:   addr_d = Base - four_n + 32'd4;
            default: addr_d = Base - four_n;
          endcase
          if (cnt != 5'd0) state_d = S_XFER;
          else if (W)      state_d = S_WB;
          else             state_d = S_DONE;
        end
      end
      S_XFER: begin
        Busy    = 1'b1;
        MemAddr = addr_q;
        if (!l_q) begin
          A2    = cur_r;
          MemWE = 1'b1;
          MemWD = RD2;
        end else if (cur_r == 4'd15) begin
          PCWrite = 1'b1;
          PCData  = ReadData;
        end else begin
          A3  = cur_r;
          WE3 = 1'b1;
          WD3 = ReadData;
        end
        mask_d = mask_clr;
        addr_d = addr_q + 32'd4;
        if (mask_clr == 16'd0) state_d = w_q ? S_WB : S_DONE;
      end
      S_WB: begin
        Busy    = 1'b1;
        A3      = rn_q;
        WD3     = fbase_q;
        // A loaded base register keeps the loaded value; R15 is never written back.
        WE3     = !((rn_q == 4'd15) || (l_q && rn_hit_q));
        state_d = S_DONE;
      end
      S_DONE: begin
        Busy    = 1'b1;
        Done    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_ldm_stm_sequencer.sv
// Scoreboard bench for ldm_stm_sequencer: directed transfers push expected per-cycle outputs,
// a negedge monitor pops one entry for every Busy cycle and checks idle cycles are all-zero.
module tb_ldm_stm_sequencer;

  logic        clk = 1'b0;
  logic        Reset, Start, L, P, U, W;
  logic [3:0]  Rn;
  logic [15:0] RegList;
  logic [31:0] Base, RD2, ReadData;
  logic        Busy, Done, WE3, MemWE, PCWrite;
  logic [3:0]  A2, A3;
  logic [31:0] WD3, MemAddr, MemWD, PCData;

  always #5 clk = ~clk;

  // Environment: register file returns a tag of the address, memory returns a tag of the address.
  assign RD2      = {28'hD000000, A2};
  assign ReadData = MemAddr ^ 32'h5A5A_0000;

  ldm_stm_sequencer dut (
    .CLK_n(clk), .Reset(Reset), .Start(Start), .L(L), .P(P), .U(U), .W(W),
    .Rn(Rn), .RegList(RegList), .Base(Base), .RD2(RD2), .ReadData(ReadData),
    .Busy(Busy), .Done(Done), .A2(A2), .A3(A3), .WE3(WE3), .WD3(WD3),
    .MemAddr(MemAddr), .MemWE(MemWE), .MemWD(MemWD), .PCWrite(PCWrite), .PCData(PCData)
  );

  typedef struct packed {
    logic        done;
    logic        memwe;
    logic        we3;
    logic        pcwrite;
    logic [31:0] memaddr;
    logic [31:0] memwd;
    logic [3:0]  a2;
    logic [3:0]  a3;
    logic [31:0] wd3;
    logic [31:0] pcdata;
  } obs_t;

  obs_t  q[$];
  obs_t  mon_a, mon_e;
  int    n_tests = 0;
  int    n_fail  = 0;
  string tag = "reset";

  function automatic obs_t sample();
    obs_t o;
    o.done = Done; o.memwe = MemWE; o.we3 = WE3; o.pcwrite = PCWrite;
    o.memaddr = MemAddr; o.memwd = MemWD; o.a2 = A2; o.a3 = A3;
    o.wd3 = WD3; o.pcdata = PCData;
    return o;
  endfunction

  function automatic string fmt(input obs_t o);
    return $sformatf("done=%b memwe=%b we3=%b pcw=%b addr=%h memwd=%h a2=%0d a3=%0d wd3=%h pc=%h",
                     o.done, o.memwe, o.we3, o.pcwrite, o.memaddr, o.memwd, o.a2, o.a3, o.wd3, o.pcdata);
  endfunction

  function automatic obs_t ex_x(input logic ld, input logic [31:0] addr, input logic [3:0] r);
    obs_t o = '0;
    o.memaddr = addr;
    if (!ld) begin
      o.memwe = 1'b1; o.a2 = r; o.memwd = {28'hD000000, r};
    end else if (r == 4'd15) begin
      o.pcwrite = 1'b1; o.pcdata = addr ^ 32'h5A5A_0000;
    end else begin
      o.we3 = 1'b1; o.a3 = r; o.wd3 = addr ^ 32'h5A5A_0000;
    end
    return o;
  endfunction

  function automatic obs_t ex_wb(input logic [3:0] rn, input logic [31:0] val, input logic we);
    obs_t o = '0;
    o.a3 = rn; o.wd3 = val; o.we3 = we;
    return o;
  endfunction

  function automatic obs_t ex_done();
    obs_t o = '0;
    o.done = 1'b1;
    return o;
  endfunction

  // Monitor: every Busy cycle consumes one expected entry; idle cycles must drive all zeros.
  always @(negedge clk) begin
    if (!Reset) begin
      mon_a = sample();
      n_tests++;
      if (Busy) begin
        if (q.size() == 0) begin
          n_fail++;
          $display("FAIL %0s unexpected_busy: got %0s", tag, fmt(mon_a));
        end else begin
          mon_e = q.pop_front();
          if (mon_a !== mon_e) begin
            n_fail++;
            $display("FAIL %0s step: got %0s | exp %0s", tag, fmt(mon_a), fmt(mon_e));
          end
        end
      end else if (mon_a !== '0) begin
        n_fail++;
        $display("FAIL %0s idle_outputs: got %0s | exp all zero", tag, fmt(mon_a));
      end
    end
  end

  task automatic start_xfer(input logic l, input logic p, input logic u, input logic w,
                            input logic [3:0] rn, input logic [15:0] list, input logic [31:0] base);
    L = l; P = p; U = u; W = w; Rn = rn; RegList = list; Base = base; Start = 1'b1;
    @(posedge clk); #1;
    Start = 1'b0; L = 1'b0; P = 1'b0; U = 1'b0; W = 1'b0; Rn = 4'd0; RegList = 16'd0; Base = 32'd0;
  endtask

  task automatic drain();
    for (int k = 0; k < 60 && q.size() != 0; k++) begin
      @(posedge clk); #1;
    end
    n_tests++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL %0s drain_timeout: %0d entries left, required 0", tag, q.size());
      q.delete();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    Reset = 1'b1; Start = 1'b0; L = 1'b0; P = 1'b0; U = 1'b0; W = 1'b0;
    Rn = 4'd0; RegList = 16'd0; Base = 32'd0;
    #2;
    n_tests++;
    if (sample() !== '0 || Busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_state: got busy=%b %0s, required all zero", Busy, fmt(sample()));
    end
    repeat (2) @(posedge clk);
    #1 Reset = 1'b0;
    @(posedge clk); #1;

    tag = "stmia";
    q.push_back(ex_x(0, 32'h100, 4'd1)); q.push_back(ex_x(0, 32'h104, 4'd2));
    q.push_back(ex_x(0, 32'h108, 4'd3)); q.push_back(ex_wb(4'd13, 32'h10C, 1'b1));
    q.push_back(ex_done());
    start_xfer(0, 0, 1, 1, 4'd13, 16'h000E, 32'h100);
    drain();

    tag = "ldmdb";
    q.push_back(ex_x(1, 32'h1F4, 4'd0)); q.push_back(ex_x(1, 32'h1F8, 4'd4));
    q.push_back(ex_x(1, 32'h1FC, 4'd15)); q.push_back(ex_done());
    start_xfer(1, 1, 0, 0, 4'd5, 16'h8011, 32'h200);
    drain();

    tag = "stmib";
    q.push_back(ex_x(0, 32'h44, 4'd0)); q.push_back(ex_x(0, 32'h48, 4'd1));
    q.push_back(ex_wb(4'd3, 32'h48, 1'b1)); q.push_back(ex_done());
    start_xfer(0, 1, 1, 1, 4'd3, 16'h0003, 32'h40);
    drain();

    tag = "ldmda";
    q.push_back(ex_x(1, 32'h3C, 4'd0)); q.push_back(ex_x(1, 32'h40, 4'd1));
    q.push_back(ex_wb(4'd6, 32'h38, 1'b1)); q.push_back(ex_done());
    start_xfer(1, 0, 0, 1, 4'd6, 16'h0003, 32'h40);
    drain();

    tag = "empty_wb";
    q.push_back(ex_wb(4'd4, 32'h1234, 1'b1)); q.push_back(ex_done());
    start_xfer(0, 0, 1, 1, 4'd4, 16'h0000, 32'h1234);
    drain();

    tag = "empty_nowb";
    q.push_back(ex_done());
    start_xfer(1, 1, 0, 0, 4'd7, 16'h0000, 32'h999);
    drain();

    tag = "ldm_rn_in_list";
    q.push_back(ex_x(1, 32'h80, 4'd2)); q.push_back(ex_wb(4'd2, 32'h84, 1'b0));
    q.push_back(ex_done());
    start_xfer(1, 0, 1, 1, 4'd2, 16'h0004, 32'h80);
    drain();

    tag = "stm_rn15";
    q.push_back(ex_x(0, 32'h10, 4'd0)); q.push_back(ex_wb(4'd15, 32'h14, 1'b0));
    q.push_back(ex_done());
    start_xfer(0, 0, 1, 1, 4'd15, 16'h0001, 32'h10);
    drain();

    tag = "reset_mid";
    q.push_back(ex_x(0, 32'h300, 4'd4)); q.push_back(ex_x(0, 32'h304, 4'd5));
    start_xfer(0, 0, 1, 1, 4'd1, 16'h00F0, 32'h300);
    @(posedge clk); #1;
    Reset = 1'b1;
    #1;
    n_tests++;
    if (sample() !== '0 || Busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_mid_outputs: got busy=%b %0s, required all zero", Busy, fmt(sample()));
    end
    q.delete();
    @(posedge clk); #1 Reset = 1'b0;
    tag = "after_reset";
    q.push_back(ex_x(0, 32'h300, 4'd4)); q.push_back(ex_x(0, 32'h304, 4'd5));
    q.push_back(ex_x(0, 32'h308, 4'd6)); q.push_back(ex_x(0, 32'h30C, 4'd7));
    q.push_back(ex_wb(4'd1, 32'h310, 1'b1)); q.push_back(ex_done());
    start_xfer(0, 0, 1, 1, 4'd1, 16'h00F0, 32'h300);
    drain();

    tag = "start_busy";
    q.push_back(ex_x(0, 32'h4F8, 4'd1)); q.push_back(ex_x(0, 32'h4FC, 4'd8));
    q.push_back(ex_wb(4'd9, 32'h4F8, 1'b1)); q.push_back(ex_done());
    start_xfer(0, 1, 0, 1, 4'd9, 16'h0102, 32'h500);
    L = 1'b1; RegList = 16'hFFFF; Base = 32'h0; Rn = 4'd3; Start = 1'b1;
    @(posedge clk); #1;
    Start = 1'b0; L = 1'b0; RegList = 16'd0; Rn = 4'd0;
    drain();

    @(posedge clk); #1;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
